// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port word memory between the CPU and loader ports
module mem_port_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t              state, state_nx;
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                prio_l_q;
    logic [DATA_W-1:0]   c_rdata_q;
    logic [DATA_W-1:0]   l_rdata_q;
    logic                arb;
    logic                sel_l;
    assign arb   = (state != ACCESS) & (c_req | l_req);
    assign sel_l = l_req & (~c_req | prio_l_q);
    // state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    // every access is one ACCESS cycle then one RESP cycle, which may chain straight into the next ACCESS
    always_comb begin
        state_nx = (state == ACCESS) ? RESP : (arb ? ACCESS : IDLE);
    end
    // command latch, round-robin pointer and per-port read data hold registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            prio_l_q  <= 1'b0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            if (arb) begin
                owner_q <= sel_l;
                we_q    <= sel_l ? l_we : c_we;
                addr_q  <= sel_l ? l_addr : c_addr;
                wdata_q <= sel_l ? l_wdata : c_wdata;
            end
            if (state == ACCESS) prio_l_q <= ~owner_q;
            if (c_rvalid) c_rdata_q <= mem_rdata;
            if (l_rvalid) l_rdata_q <= mem_rdata;
        end
    end
    // memory strobe, grants and read responses decoded from state and the latched command
    always_comb begin
        mem_en    = state == ACCESS;
        mem_we    = mem_en & we_q;
        mem_addr  = mem_en ? addr_q : '0;
        mem_wdata = mem_en ? wdata_q : '0;
        c_gnt     = mem_en & ~owner_q;
        l_gnt     = mem_en & owner_q;
        c_rvalid  = (state == RESP) & ~we_q & ~owner_q;
        l_rvalid  = (state == RESP) & ~we_q & owner_q;
        c_rdata   = c_rvalid ? mem_rdata : c_rdata_q;
        l_rdata   = l_rvalid ? mem_rdata : l_rdata_q;
        busy      = state != IDLE;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the two-port memory arbiter
module tb_mem_port_arbiter;
    localparam int AW = 7;
    localparam int DW = 16;
    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [AW-1:0] c_addr = '0, l_addr = '0;
    logic [DW-1:0] c_wdata = '0, l_wdata = '0;
    logic          c_gnt, c_rvalid, l_gnt, l_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] c_rdata, l_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {logic port; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} gnt_t;
    typedef struct packed {logic port; logic [DW-1:0] data;} rd_t;
    gnt_t gnt_q[$];
    rd_t  rd_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void exp_gnt(input logic p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_t e;
        e.port = p; e.we = we; e.addr = a; e.wdata = d;
        gnt_q.push_back(e);
    endfunction

    function automatic void exp_rd(input logic p, input logic [DW-1:0] d);
        rd_t r;
        r.port = p; r.data = d;
        rd_q.push_back(r);
    endfunction

    // memory array model: preset contents, 1-cycle synchronous read
    logic [DW-1:0] mem [128];
    bit            written [128];
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        case (a)
            7'd10:   return 16'h8201;
            7'd11:   return 16'h1234;
            7'd12:   return 16'h0BEE;
            7'd20:   return 16'h00AA;
            7'd21:   return 16'h5500;
            7'd30:   return 16'h0C30;
            7'd40:   return 16'h0D40;
            default: return '0;
        endcase
    endfunction
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT shows a grant or a read response
    bit prev_c = 1'b0, prev_l = 1'b0;
    always @(negedge clock) begin
        if (c_rvalid | prev_c) chk("c_rvalid_latency", c_rvalid, prev_c);
        if (l_rvalid | prev_l) chk("l_rvalid_latency", l_rvalid, prev_l);
        if (!mem_en && {mem_we, mem_addr, mem_wdata} != 0) chk("mem_idle_zero", {mem_we, mem_addr, mem_wdata}, 0);
        if (c_gnt | l_gnt | mem_en) begin
            if (gnt_q.size() == 0) chk("unexpected_gnt", {mem_en, c_gnt, l_gnt}, 0);
            else begin
                gnt_t e;
                e = gnt_q.pop_front();
                chk("gnt_cmd", {c_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata},
                    {~e.port, e.port, 1'b1, e.we, e.addr, e.wdata});
            end
        end
        if (c_rvalid | l_rvalid) begin
            if (rd_q.size() == 0) chk("unexpected_rvalid", {c_rvalid, l_rvalid}, 0);
            else begin
                rd_t r;
                r = rd_q.pop_front();
                chk("read_resp", {c_rvalid, l_rvalid, r.port ? l_rdata : c_rdata}, {~r.port, r.port, r.data});
            end
        end
        prev_c <= c_gnt & ~mem_we & reset_n;
        prev_l <= l_gnt & ~mem_we & reset_n;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_gnt(input logic port, output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!(port ? l_gnt : c_gnt) && cyc < 20);
        if (!(port ? l_gnt : c_gnt)) chk("gnt_timeout", port ? l_gnt : c_gnt, 1);
    endtask

    task automatic cpu_rw(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int cyc);
        c_we = we; c_addr = a; c_wdata = d; c_req = 1'b1;
        wait_gnt(1'b0, cyc);
        @(posedge clock); #1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    endtask

    task automatic ld_rw(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int cyc);
        l_we = we; l_addr = a; l_wdata = d; l_req = 1'b1;
        wait_gnt(1'b1, cyc);
        @(posedge clock); #1;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc_c, cyc_l, cyc, n, last;
        // reset held with both requests pending
        repeat (2) @(posedge clock);
        #1;
        c_req = 1'b1; l_req = 1'b1; c_addr = 7'd11; l_addr = 7'd12;
        @(posedge clock);
        @(negedge clock);
        chk("reset_ctrl", {c_gnt, l_gnt, c_rvalid, l_rvalid, mem_en, mem_we, busy}, 0);
        chk("reset_mem", {mem_addr, mem_wdata}, 0);
        chk("reset_rdata", {c_rdata, l_rdata}, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        exp_gnt(1'b0, 1'b0, 7'd11, 16'h0); exp_gnt(1'b1, 1'b0, 7'd12, 16'h0);
        exp_rd(1'b0, 16'h1234); exp_rd(1'b1, 16'h0BEE);
        fork
            cpu_rw(1'b0, 7'd11, 16'h0, cyc_c);
            ld_rw(1'b0, 7'd12, 16'h0, cyc_l);
        join
        chk("cpu_first_latency", cyc_c, 2);
        chk("loader_second_latency", cyc_l, 4);
        // plain CPU read
        idle(2);
        exp_gnt(1'b0, 1'b0, 7'd10, 16'h0); exp_rd(1'b0, 16'h8201);
        cpu_rw(1'b0, 7'd10, 16'h0, cyc);
        chk("cpu_read_latency", cyc, 2);
        // loader write then CPU read-back, then loader read leaves CPU data untouched
        idle(2);
        exp_gnt(1'b1, 1'b1, 7'd0, 16'd4);
        ld_rw(1'b1, 7'd0, 16'd4, cyc);
        idle(2);
        exp_gnt(1'b0, 1'b0, 7'd0, 16'h0); exp_rd(1'b0, 16'd4);
        cpu_rw(1'b0, 7'd0, 16'h0, cyc);
        idle(2);
        exp_gnt(1'b1, 1'b0, 7'd10, 16'h0); exp_rd(1'b1, 16'h8201);
        ld_rw(1'b0, 7'd10, 16'h0, cyc);
        idle(2);
        @(negedge clock);
        chk("c_rdata_hold", c_rdata, 16'd4);
        chk("l_rdata_hold", l_rdata, 16'h8201);
        // both ports requesting continuously: strict alternation every two cycles
        idle(2);
        for (int i = 0; i < 8; i++) begin
            exp_gnt(i[0], 1'b0, i[0] ? 7'd21 : 7'd20, 16'h0);
            exp_rd(i[0], i[0] ? 16'h5500 : 16'h00AA);
        end
        c_addr = 7'd20; c_req = 1'b1; l_addr = 7'd21; l_req = 1'b1;
        n = 0; last = 0; cyc = 0;
        while (n < 8 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (c_gnt | l_gnt) begin
                if (n > 0) chk("access_spacing", cyc - last, 2);
                last = cyc;
                n++;
            end
        end
        chk("rr_access_count", n, 8);
        @(posedge clock); #1;
        c_req = 1'b0; l_req = 1'b0; c_addr = '0; l_addr = '0;
        // loader request withdrawn before it is ever sampled
        idle(2);
        exp_gnt(1'b0, 1'b0, 7'd30, 16'h0); exp_rd(1'b0, 16'h0C30);
        c_addr = 7'd30; c_req = 1'b1;
        @(posedge clock); #1;
        l_addr = 7'd31; l_req = 1'b1;
        @(negedge clock);
        chk("withdraw_c_gnt", c_gnt, 1);
        @(posedge clock); #1;
        c_req = 1'b0; l_req = 1'b0; c_addr = '0; l_addr = '0;
        idle(4);
        @(negedge clock);
        chk("withdraw_idle", busy, 0);
        // reset during the ACCESS cycle of a read drops the response
        idle(2);
        exp_gnt(1'b0, 1'b0, 7'd40, 16'h0);
        c_addr = 7'd40; c_req = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(negedge clock);
        chk("reset_access_gnt", c_gnt, 1);
        @(posedge clock); #1;
        c_req = 1'b0; c_addr = '0;
        @(negedge clock);
        chk("reset_abort_ctrl", {busy, c_rvalid, l_rvalid, mem_en}, 0);
        chk("reset_abort_rdata", {c_rdata, l_rdata}, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(3);
        chk("gnt_queue_empty", gnt_q.size(), 0);
        chk("rd_queue_empty", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
